// File: rtl/prog_encoder.sv
// Program-memory loader: encodes instruction fields into 16-bit cell words, buffers
// them in a small FIFO and writes them sequentially. Define PROG_ENC_PARITY_EN for even parity in bit 15.
module prog_encoder #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic              in_r0,
  input  logic              in_r1,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              wrap
);

  localparam int              PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [ADDR_W:0] WC_MAX   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [3:0]      OP_RST   = 4'h0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [15:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_nx;
  logic [PTR_W:0]     fifo_cnt_q, fifo_cnt_d, cnt_after_pop;
  logic [15:0]        enc_word;
  logic               push, pop, start_acc;
  logic               mem_we_q, mem_we_d;
  logic [15:0]        mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [ADDR_W:0]    word_count_q;
  logic               wrap_q;

  assign in_ready   = (state_q == S_RUN) && (fifo_cnt_q != CNT_FULL);
  assign push       = in_valid && in_ready;
  assign pop        = mem_we_q && mem_ready;
  assign start_acc  = (state_q == S_IDLE) && start;
  assign rd_ptr_nx  = rd_ptr_q + PTR_W'(1);

  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_addr   = mem_addr_q;
  assign word_count = word_count_q;
  assign wrap       = wrap_q;
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);

  // RST carries no register operands, so its select bits are cleared.
  always_comb begin
    enc_word       = '0;
    enc_word[11:8] = in_opcode;
    enc_word[7:0]  = in_data;
    if (in_opcode != OP_RST) begin
      enc_word[13] = in_r1;
      enc_word[12] = in_r0;
    end
`ifdef PROG_ENC_PARITY_EN
    enc_word[15] = ^enc_word[14:0];
`endif
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (push && in_last) state_d = S_DRAIN;
      S_DRAIN: if (fifo_cnt_q == '0 && !mem_we_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The head word stays in the FIFO until its write is accepted; the output
  // register always shows the head that will be current after this edge.
  always_comb begin
    cnt_after_pop = pop ? fifo_cnt_q - CNT_ONE : fifo_cnt_q;
    fifo_cnt_d    = push ? cnt_after_pop + CNT_ONE : cnt_after_pop;
    mem_we_d      = (cnt_after_pop != '0);
    mem_wdata_d   = mem_wdata_q;
    if (mem_we_d) mem_wdata_d = pop ? fifo_mem[rd_ptr_nx] : fifo_mem[rd_ptr_q];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the storage array has no reset; the count and pointers mark what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= enc_word;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_nx;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      mem_addr_q   <= '0;
      word_count_q <= '0;
      wrap_q       <= 1'b0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      if (start_acc) begin
        mem_addr_q   <= base_addr;
        word_count_q <= '0;
        wrap_q       <= 1'b0;
      end else if (pop) begin
        mem_addr_q <= mem_addr_q + ADDR_W'(1);
        if (&mem_addr_q) wrap_q <= 1'b1;
        if (word_count_q != WC_MAX) word_count_q <= word_count_q + (ADDR_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_prog_encoder.sv
// Self-checking bench for prog_encoder: directed loads plus randomized fields and
// write backpressure, checked against a word-queue reference model.
module tb_prog_encoder;

  localparam logic [3:0] OP_RST = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_ST  = 4'h2;

  logic        clk = 1'b0;
  logic        rstn, start, in_valid, in_ready, in_r0, in_r1, in_last;
  logic        mem_we, mem_ready, busy, done, wrap;
  logic [7:0]  base_addr, in_data, mem_addr;
  logic [3:0]  in_opcode;
  logic [15:0] mem_wdata;
  logic [8:0]  word_count;

  prog_encoder #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_r0(in_r0), .in_r1(in_r1), .in_data(in_data), .in_last(in_last),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .word_count(word_count), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  int          exp_addr = 0;
  int          cur_base = 0;
  bit          rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoding from the word-format rules, using plain arithmetic.
  function automatic logic [15:0] model_word(input int op, input int r0, input int r1, input int data);
    int w;
    w = op * 256 + data;
    if (op != int'(OP_RST)) w = w + r1 * 8192 + r0 * 4096;
`ifdef PROG_ENC_PARITY_EN
    begin
      int ones;
      ones = 0;
      for (int b = 0; b < 15; b++) ones += (w >> b) & 1;
      if (ones % 2 == 1) w = w + 32768;
    end
`endif
    return w[15:0];
  endfunction

  // One clock cycle: inputs are already driven; DUT outputs are register-based
  // and stable here at the falling edge.
  task automatic step();
    logic [15:0] hd;
    if (rand_rdy) mem_ready = 1'($urandom_range(0, 1));
    if (mem_we) begin
      if (exp_q.size() == 0) check("spurious_write", 32'(mem_we), 32'(0));
      else begin
        check("wr_addr", 32'(mem_addr), 32'(exp_addr));
        check("wr_data", 32'(mem_wdata), 32'(exp_q[0]));
        if (mem_ready) begin
          hd = exp_q.pop_front();
          exp_addr = (exp_addr + 1) % 256;
        end
      end
    end
    if (in_valid && in_ready)
      exp_q.push_back(model_word(int'(in_opcode), int'(in_r0), int'(in_r1), int'(in_data)));
    @(negedge clk);
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready",   32'(in_ready),   32'(0));
    check("rst_mem_we",     32'(mem_we),     32'(0));
    check("rst_mem_addr",   32'(mem_addr),   32'(0));
    check("rst_mem_wdata",  32'(mem_wdata),  32'(0));
    check("rst_busy",       32'(busy),       32'(0));
    check("rst_done",       32'(done),       32'(0));
    check("rst_word_count", 32'(word_count), 32'(0));
    check("rst_wrap",       32'(wrap),       32'(0));
  endtask

  task automatic start_load(input logic [7:0] base);
    start = 1'b1;
    base_addr = base;
    exp_addr = int'(base);
    cur_base = int'(base);
    step();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'(1));
  endtask

  task automatic send(input logic [3:0] op, input logic r0, input logic r1,
                      input logic [7:0] d, input logic last);
    int n;
    bit acc;
    n = 0;
    in_valid = 1'b1; in_opcode = op; in_r0 = r0; in_r1 = r1; in_data = d; in_last = last;
    do begin
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_accept_timeout", 32'(in_ready), 32'(1));
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_rand(input logic last);
    send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         8'($urandom_range(0, 255)), last);
  endtask

  task automatic wait_done(input int sent);
    int n;
    n = 0;
    while (!done && n < 400) begin
      step();
      n++;
    end
    check("done_pulse", 32'(done), 32'(1));
    check("word_count", 32'(word_count), 32'((sent > 256) ? 256 : sent));
    check("wrap", 32'(wrap), 32'((cur_base + sent >= 256) ? 1 : 0));
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    check("busy_in_done", 32'(busy), 32'(0));
    step();
    check("done_one_cycle", 32'(done), 32'(0));
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_opcode = '0;
    in_r0 = 1'b0; in_r1 = 1'b0; in_data = '0; in_last = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    check_reset_vals();
    @(negedge clk);
    rstn = 1'b1;
    step();

    // Single LD instruction; write strobe one cycle after the push edge
    start_load(8'h10);
    send(OP_LD, 1'b1, 1'b0, 8'h5A, 1'b1);
    check("we_low_at_push", 32'(mem_we), 32'(0));
    step();
    check("we_latency", 32'(mem_we), 32'(1));
    wait_done(1);

    // RST masks register selects; data passes through
    start_load(8'h20);
    send(OP_RST, 1'b1, 1'b1, 8'hFF, 1'b0);
    send(OP_ST, 1'b1, 1'b0, 8'h34, 1'b0);
    send(OP_RST, 1'b0, 1'b0, 8'h03, 1'b1);
    wait_done(3);

    // Backpressure: FIFO fills to 4, stray start ignored, then drains
    mem_ready = 1'b0;
    start_load(8'h40);
    for (int i = 0; i < 4; i++) send_rand(1'b0);
    check("in_ready_full", 32'(in_ready), 32'(0));
    check("we_stalled", 32'(mem_we), 32'(1));
    start = 1'b1;
    base_addr = 8'h99;
    step();
    step();
    start = 1'b0;
    step();
    mem_ready = 1'b1;
    send_rand(1'b0);
    send_rand(1'b1);
    wait_done(6);

    // Address wrap
    start_load(8'hFE);
    for (int i = 0; i < 3; i++) send_rand(1'(i == 2));
    wait_done(3);

    // word_count saturation
    start_load(8'h00);
    for (int i = 0; i < 257; i++) send_rand(1'(i == 256));
    wait_done(257);

    // Randomized loads with random write backpressure
    rand_rdy = 1'b1;
    for (int l = 0; l < 4; l++) begin
      int len;
      len = int'($urandom_range(1, 10));
      start_load(8'($urandom_range(0, 255)));
      for (int i = 0; i < len; i++) send_rand(1'(i == len - 1));
      wait_done(len);
    end
    rand_rdy = 1'b0;
    mem_ready = 1'b1;

    // Reset with two words buffered
    mem_ready = 1'b0;
    start_load(8'h30);
    send_rand(1'b0);
    send_rand(1'b0);
    step();
    #2 rstn = 1'b0;
    #1 check_reset_vals();
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("no_write_after_reset", 32'(mem_we), 32'(0));
    check("idle_after_reset", 32'(busy), 32'(0));
    start_load(8'h50);
    send_rand(1'b0);
    send_rand(1'b1);
    wait_done(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
